// File: rtl/cpu_dbg_pkg.sv
// Shared CPU debug definitions: register file geometry and scan FSM states.
package cpu_dbg_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rf_scan_reader.sv
// Register file scan reader: walks first..last (wrapping mod NREGS) through
// one RF read port and streams captured values as idx/data beats.
module rf_scan_reader
  import cpu_dbg_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_end_idx;
  logic [AW-1:0] r_out_idx;
  logic [DW-1:0] r_out_data;
  logic          w_hs;
  logic          w_last;

  assign w_hs   = (r_state == SEND) && out_ready;
  assign w_last = (r_idx == r_end_idx);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = READ;
      READ: w_next = SEND;
      SEND: if (w_hs) w_next = w_last ? DONE : READ;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  // Index walk and beat capture. An aborted cycle leaves all data untouched;
  // the FSM alone discards the partial scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_end_idx  <= '0;
      r_out_idx  <= '0;
      r_out_data <= '0;
    end else if (!abort) begin
      case (r_state)
        IDLE: if (start) begin
          r_idx     <= first;
          r_end_idx <= last;
        end
        READ: begin
          r_out_idx  <= r_idx;
          r_out_data <= rf_data;
        end
        SEND: if (w_hs && !w_last) r_idx <= r_idx + AW'(1);
        default: ;
      endcase
    end
  end

  assign rf_addr   = r_idx;
  assign out_valid = (r_state == SEND);
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign busy      = (r_state == READ) || (r_state == SEND);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_rf_scan_reader.sv
// Directed scoreboard bench for rf_scan_reader with a behavioural RF.
module tb_rf_scan_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first = '0;
  logic [4:0]  last = '0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  typedef struct { logic [4:0] idx; logic [31:0] data; } beat_t;

  logic [31:0] rf [32];
  beat_t       q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  // x0 is hardwired to zero regardless of storage contents.
  assign rf_data = (rf_addr == 5'd0) ? 32'h0 : rf[rf_addr];

  rf_scan_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first(first), .last(last), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected beats for a scan, taken from the RF as it stands now.
  task automatic push_scan(input int f, input int l);
    int n;
    beat_t b;
    n = (((l - f) % 32) + 32) % 32 + 1;
    for (int k = 0; k < n; k++) begin
      b.idx  = 5'((f + k) % 32);
      b.data = (b.idx == 5'd0) ? 32'h0 : rf[b.idx];
      q.push_back(b);
    end
  endtask

  task automatic go(input int f, input int l, input bit expect_beats);
    start = 1'b1;
    first = 5'(f);
    last  = 5'(l);
    if (expect_beats) push_scan(f, l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 32'(done_cnt - base), 32'd1);
    chk({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: every accepted beat is popped and compared in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready && !abort) begin
        if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_idx", 32'(out_idx), 32'(e.idx));
          chk("beat_data", out_data, e.data);
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    rf[0]  = 32'hFFFF_FFFF;
    rf[5]  = 32'hDEAD_BEEF;
    rf[6]  = 32'h0000_0001;
    rf[7]  = 32'h1234_5678;
    rf[31] = 32'hCAFE_F00D;

    // Reset values.
    #1;
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Two-beat scan with exact cycle timing.
    base = done_cnt;
    go(5, 6, 1'b1);
    @(posedge clk); #1;
    chk("t1_E1_valid", 32'(out_valid), 32'd1);
    chk("t1_E1_idx", 32'(out_idx), 32'd5);
    chk("t1_E1_data", out_data, 32'hDEAD_BEEF);
    chk("t1_E1_busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_E3_valid", 32'(out_valid), 32'd1);
    chk("t1_E3_idx", 32'(out_idx), 32'd6);
    chk("t1_E3_data", out_data, 32'h0000_0001);
    @(posedge clk); #1;
    chk("t1_E4_done", 32'(done), 32'd1);
    chk("t1_E4_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_E5_busy", 32'(busy), 32'd0);
    chk("t1_E5_done", 32'(done), 32'd0);
    chk("t1_done_once", 32'(done_cnt - base), 32'd1);
    chk("t1_sb_empty", 32'(q.size()), 32'd0);

    // Full scan 0..31, 64 cycles to last handshake.
    go(0, 31, 1'b1);
    wait_done("full", 80);

    // Wrapping scan 30,31,0,1.
    go(30, 1, 1'b1);
    wait_done("wrap", 20);

    // Backpressure with a write to the held register.
    out_ready = 1'b0;
    go(7, 7, 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("bp_valid_seen", 32'(n < 10), 32'd1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) rf[7] = 32'hAAAA_5555;
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_idx", 32'(out_idx), 32'd7);
      chk("bp_hold_data", out_data, 32'h1234_5678);
    end
    out_ready = 1'b1;
    wait_done("bp", 10);

    // Abort while beat idx 3 is on offer, coinciding with a handshake.
    go(0, 31, 1'b1);
    n = 0;
    while (!(out_valid && out_idx == 5'd3) && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_reach", 32'(n < 20), 32'd1);
    base = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - base), 32'd0);

    // Fresh scan restarts at first; a start while busy is ignored.
    go(0, 9, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; first = 5'd20; last = 5'd25;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("fresh", 40);

    // Asynchronous reset mid-scan.
    go(0, 31, 1'b1);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_rf_addr", 32'(rf_addr), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_idx", 32'(out_idx), 32'd0);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_scan_reader.md
# rf_scan_reader

Read-side companion to the CPU register file. On a start pulse it walks a contiguous, optionally wrapping range of architectural registers through one RF read port. It captures each 32-bit value and streams it as index/data beats over a valid/ready interface. The consumer is the board display/UART debug path in the complex-application top level, alongside the pipelined CPU.

## Interface
- NREGS, 32, number of architectural registers (x0..x31)
- AW, 5, register address width
- DW, 32, register data width

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- abort  in  1  cancel scan; takes priority over all other inputs except rst
- first  in  AW  first register index; sampled with start
- last  in  AW  last register index; sampled with start
- rf_addr  out  AW  drives an RF read address port
- rf_data  in  DW  combinational RF read data for rf_addr; x0 reads 0
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_idx  out  AW  register index of current beat
- out_data  out  DW  captured register value
- busy  out  1  high in READ or SEND
- done  out  1  one-cycle pulse after last beat accepted

## Operation
- States:
  - IDLE: busy=0, out_valid=0.
  - READ: rf_addr=idx; rf_data is captured into out_data at the end of the cycle.
  - SEND: out_valid=1.
  - DONE: done=1 for one cycle.
- IDLE to READ on start=1. Latch first into idx and last into end_idx.
- READ to SEND unconditionally. out_idx<=idx, out_data<=rf_data.
- SEND holds while out_ready=0. out_idx and out_data are stable and out_valid stays high.
- SEND on handshake (out_valid&out_ready):
  - if idx==end_idx, go to DONE;
  - else idx<=idx+1 mod 32 and go to READ.
- DONE to IDLE unconditionally.
- Wrap-around: if first>last, the scan runs first..31,0..last. Beat count = ((last-first) mod 32)+1. first==last gives exactly 1 beat.
- Index 0 always yields data 0, because the RF hardwires it.
- Snapshot semantics: each value is the RF content during its READ cycle.
  - A CPU write to that register after READ is not reflected in the pending beat.
  - A write before READ is reflected.
- start while busy or in DONE is ignored; no queuing.
- abort in any state: go to IDLE on the next edge. out_valid drops that edge, no done pulse, partial scan discarded.
- abort and handshake in the same cycle: abort wins; no done.
- rf_addr is registered idx in all states. In IDLE it holds the last value (0 after reset).

## Timing
- Reset values: state=IDLE, idx=0, end_idx=0, rf_addr=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0.
- rst asserted mid-scan clears everything immediately. The beat in flight is lost.
- start sampled at edge E0, giving READ in cycle E0..E1 and out_valid=1 from E1.
- With out_ready held high, one beat every 2 cycles. A full 0..31 scan takes 64 cycles from start edge to the last handshake, with done in the following cycle.
- Back-to-back scans: the earliest next start is sampled the cycle after done, i.e. in IDLE.
- Every beat has exactly one READ cycle before it. out_data never changes while out_valid=1.

## Structure
- Shared package (cpu_dbg_pkg) holds:
  - state enum {IDLE, READ, SEND, DONE};
  - AW/DW/NREGS constants, shared with RF instantiation.
- Single flat module; no sub-module warranted.
- Instantiate at top level next to the RF. The RF's third read port (or a debug mux on A2 when the CPU is halted) is fed by rf_addr.

## Test plan
- Preload x5=0xDEADBEEF, x6=0x00000001. start with first=5, last=6, ready=1 -> beats (5,0xDEADBEEF) at E1 and (6,0x00000001) at E3; done pulse at E4; busy low at E5.
- Full scan first=0, last=31, ready=1 -> 32 beats in index order; idx 0 data=0; x31 value matches the preload; done exactly once.
- Wrap: first=30, last=1 -> beats with idx 30,31,0,1 in that order, then done.
- Backpressure: ready=0 for 5 cycles on beat x7=0x12345678 -> out_valid, out_idx and out_data stable throughout. Write x7=0xAAAA5555 during the hold: held beat still 0x12345678.
- abort during SEND of beat 3 of 0..31 -> out_valid=0 next cycle, no done. A fresh start then returns from first again.
- rst pulse mid-scan -> all outputs 0 asynchronously. A start while busy, issued after the fresh start, has no effect on the beat sequence.
